// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART TX among NREQ
// requesters. Optional issue timeout via `UART_ARB_TIMEOUT_EN.
// Ports: clk, rst (sync, active high); req/req_data/req_par_en in, ack out;
// tx_data/tx_data_valid/tx_par_en out, tx_busy in; grant_id, arb_busy,
// err_timeout status outputs. All outputs are registered.
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int TO_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       req_data,
  input  logic [NREQ-1:0]          req_par_en,
  output logic [NREQ-1:0]          ack,
  output logic [DW-1:0]            tx_data,
  output logic                     tx_data_valid,
  output logic                     tx_par_en,
  input  logic                     tx_busy,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     arb_busy,
  output logic                     err_timeout
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gid_q, gid_d;
  logic [DW-1:0]   data_q, data_d;
  logic            par_q, par_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            vld_q, vld_d;
  logic            abusy_q, abusy_d;
  logic            err_d;

  logic [IW-1:0]   win;
  logic            found;
  int              idx;

  // Round-robin search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q;
`else
  logic unused_to;
  assign unused_to = (TO_CYCLES > 0);
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    data_d  = data_q;
    par_d   = par_q;
    ack_d   = '0;
    vld_d   = 1'b0;
    err_d   = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!tx_busy && found) begin
          state_d    = S_ISSUE;
          ptr_d      = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
          gid_d      = win;
          data_d     = req_data[win*DW +: DW];
          par_d      = req_par_en[win];
          ack_d[win] = 1'b1;
          vld_d      = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        // Counter hitting TO_CYCLES on this cycle aborts the frame.
        else if (cnt_q == CW'(TO_CYCLES - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    abusy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      ack_q   <= '0;
      vld_q   <= 1'b0;
      abusy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      par_q   <= par_d;
      ack_q   <= ack_d;
      vld_q   <= vld_d;
      abusy_q <= abusy_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err_timeout = err_q;
`else
  logic unused_err;
  assign unused_err  = err_d;
  assign err_timeout = 1'b0;
`endif

  assign ack           = ack_q;
  assign tx_data       = data_q;
  assign tx_data_valid = vld_q;
  assign tx_par_en     = par_q;
  assign grant_id      = gid_q;
  assign arb_busy      = abusy_q;

endmodule
